// File: rtl/avl_mem_responder.sv
// avl_mem_responder: Avalon-MM slave backed by an on-chip word array. It stands in for a DDR3
// user port so Avalon-MM masters can be exercised without the hard memory controller.
// Reads have a fixed latency and return in order; backpressure comes from avl_waitrequest.
//
// Ports:
//   iCLK, iRST          clock (rising edge), synchronous active-high reset
//   avl_address         word address; bits above MEM_AW-1 must be zero, else out-of-bounds
//   avl_read/avl_write  command strobes, accepted when avl_waitrequest is low
//   avl_writedata       write data
//   avl_waitrequest     high = command not accepted this cycle (combinational)
//   avl_readdatavalid   one-cycle strobe per returned read word
//   avl_readdata        read data, valid with avl_readdatavalid
//   stall_in            test hook, forces avl_waitrequest high
//   err_oob, err_proto  sticky out-of-bounds / simultaneous read+write flags
//   wr_count, rd_count  wrapping counters of accepted writes / reads
//
// Timing: a read accepted at edge N presents its strobe in the cycle that begins at
// edge N+READ_LAT. A pending slot is held from the accept edge until the strobe cycle ends.
module avl_mem_responder #(
  parameter int unsigned ADDR_W   = 26,
  parameter int unsigned DATA_W   = 128,
  parameter int unsigned MEM_AW   = 6,   // must be < ADDR_W
  parameter int unsigned READ_LAT = 3,   // 1..8
  parameter int unsigned MAX_PEND = 4    // 1..8
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [ADDR_W-1:0] avl_address,
  input  logic              avl_read,
  input  logic              avl_write,
  input  logic [DATA_W-1:0] avl_writedata,
  output logic              avl_waitrequest,
  output logic              avl_readdatavalid,
  output logic [DATA_W-1:0] avl_readdata,
  input  logic              stall_in,
  output logic              err_oob,
  output logic              err_proto,
  output logic [15:0]       wr_count,
  output logic [15:0]       rd_count
);

  localparam int unsigned Depth = 1 << MEM_AW;
  localparam int unsigned PendW = $clog2(MAX_PEND + 1);

  logic [DATA_W-1:0] mem_q [Depth];

  logic [MEM_AW-1:0] index;
  logic              oob;
  logic              accept, wr_acc, rd_acc, proto;
  logic [DATA_W-1:0] rd_data;

  logic [PendW-1:0]  pend_q, pend_d;
  logic [READ_LAT-1:0] pv_q;
  logic [DATA_W-1:0] pd_q [READ_LAT];
  logic              rdv_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_oob_q, err_proto_q;
  logic [15:0]       wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;

  assign index  = avl_address[MEM_AW-1:0];
  assign oob    = |avl_address[ADDR_W-1:MEM_AW];

  assign avl_waitrequest = iRST | stall_in | (pend_q == PendW'(MAX_PEND));
  assign accept = (avl_read | avl_write) & ~avl_waitrequest;
  // A simultaneous read+write performs only the write.
  assign wr_acc = accept & avl_write;
  assign rd_acc = accept & avl_read & ~avl_write;
  assign proto  = accept & avl_read & avl_write;

  // Reads of the word written on the previous edge see the new value since mem_q is already
  // updated when the read samples it.
  assign rd_data = oob ? '0 : mem_q[index];

  always_comb begin
    pend_d   = pend_q;
    if (rd_acc && !rdv_q) begin
      pend_d = pend_q + PendW'(1);
    end else if (!rd_acc && rdv_q) begin
      pend_d = pend_q - PendW'(1);
    end
    wr_cnt_d = wr_acc ? wr_cnt_q + 16'd1 : wr_cnt_q;
    rd_cnt_d = rd_acc ? rd_cnt_q + 16'd1 : rd_cnt_q;
  end

  // Array is deliberately outside the reset domain; contents survive iRST.
  always_ff @(posedge iCLK) begin
    if (wr_acc && !oob) begin
      mem_q[index] <= avl_writedata;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      pend_q      <= '0;
      pv_q        <= '0;
      for (int i = 0; i < int'(READ_LAT); i++) begin
        pd_q[i] <= '0;
      end
      rdv_q       <= 1'b0;
      rdata_q     <= '0;
      err_oob_q   <= 1'b0;
      err_proto_q <= 1'b0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
    end else begin
      pend_q   <= pend_d;
      pv_q[0]  <= rd_acc;
      pd_q[0]  <= rd_acc ? rd_data : '0;
      for (int i = 1; i < int'(READ_LAT); i++) begin
        pv_q[i] <= pv_q[i-1];
        pd_q[i] <= pd_q[i-1];
      end
      rdv_q    <= pv_q[READ_LAT-1];
      rdata_q  <= pd_q[READ_LAT-1];
      if (accept && oob) begin
        err_oob_q <= 1'b1;
      end
      if (proto) begin
        err_proto_q <= 1'b1;
      end
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  assign avl_readdatavalid = rdv_q;
  assign avl_readdata      = rdata_q;
  assign err_oob           = err_oob_q;
  assign err_proto         = err_proto_q;
  assign wr_count          = wr_cnt_q;
  assign rd_count          = rd_cnt_q;

endmodule

// File: tb/tb_avl_mem_responder.sv
// Scoreboard bench for avl_mem_responder: the driver pushes the expected word and the cycle of
// its strobe when a read is accepted; a monitor pops and compares on every strobe.
module tb_avl_mem_responder;

  localparam int unsigned ADDR_W   = 26;
  localparam int unsigned DATA_W   = 128;
  localparam int unsigned MEM_AW   = 6;
  localparam int unsigned READ_LAT = 3;
  localparam int unsigned MAX_PEND = 4;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                cyc;
  } exp_t;

  logic              iCLK;
  logic              iRST;
  logic [ADDR_W-1:0] avl_address;
  logic              avl_read;
  logic              avl_write;
  logic [DATA_W-1:0] avl_writedata;
  logic              avl_waitrequest;
  logic              avl_readdatavalid;
  logic [DATA_W-1:0] avl_readdata;
  logic              stall_in;
  logic              err_oob;
  logic              err_proto;
  logic [15:0]       wr_count;
  logic [15:0]       rd_count;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  avl_mem_responder #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MEM_AW   (MEM_AW),
    .READ_LAT (READ_LAT),
    .MAX_PEND (MAX_PEND)
  ) dut (
    .iCLK              (iCLK),
    .iRST              (iRST),
    .avl_address       (avl_address),
    .avl_read          (avl_read),
    .avl_write         (avl_write),
    .avl_writedata     (avl_writedata),
    .avl_waitrequest   (avl_waitrequest),
    .avl_readdatavalid (avl_readdatavalid),
    .avl_readdata      (avl_readdata),
    .stall_in          (stall_in),
    .err_oob           (err_oob),
    .err_proto         (err_proto),
    .wr_count          (wr_count),
    .rd_count          (rd_count)
  );

  initial begin
    iCLK = 1'b0;
    forever #5 iCLK = ~iCLK;
  end

  always @(posedge iCLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation, in data and cycle.
  always @(negedge iCLK) begin
    if (avl_readdatavalid) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_strobe: got strobe with data 0x%0h, expected none (cycle %0d)",
                 avl_readdata, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("read_data", avl_readdata, e.data);
        check("read_latency", DATA_W'(cyc), DATA_W'(e.cyc));
      end
    end
  end

  // Present a command at a falling edge and hold it until accepted; leaves the bench at the
  // falling edge after the accept edge.
  task automatic cmd(input logic rd, input logic wr, input logic [ADDR_W-1:0] addr,
                     input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] exp,
                     output int retries);
    avl_read      = rd;
    avl_write     = wr;
    avl_address   = addr;
    avl_writedata = wdata;
    retries       = 0;
    #1;
    while (avl_waitrequest && retries < 20) begin
      @(negedge iCLK);
      #1;
      retries++;
    end
    if (avl_waitrequest) begin
      n_tests++;
      n_fail++;
      $display("FAIL cmd_timeout: got waitrequest 1 after %0d cycles, expected 0", retries);
    end else if (rd && !wr) begin
      sb.push_back('{exp, cyc + 1 + int'(READ_LAT)});
    end
    @(negedge iCLK);
  endtask

  task automatic idle(input int n);
    avl_read  = 1'b0;
    avl_write = 1'b0;
    repeat (n) @(negedge iCLK);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 30) begin
      @(negedge iCLK);
      k++;
    end
    check("drain_empty", DATA_W'(sb.size()), '0);
  endtask

  int r;
  int retr [6];
  logic [DATA_W-1:0] exp6 [6];

  initial begin
    iRST          = 1'b1;
    avl_address   = '0;
    avl_read      = 1'b0;
    avl_write     = 1'b0;
    avl_writedata = '0;
    stall_in      = 1'b0;
    repeat (2) @(negedge iCLK);
    #1;
    check("wait_in_reset", DATA_W'(avl_waitrequest), 1);
    @(negedge iCLK);
    iRST = 1'b0;
    @(negedge iCLK);
    check("rst_rdv", DATA_W'(avl_readdatavalid), 0);
    check("rst_rdata", avl_readdata, 0);
    check("rst_err_oob", DATA_W'(err_oob), 0);
    check("rst_err_proto", DATA_W'(err_proto), 0);
    check("rst_wr_count", DATA_W'(wr_count), 0);
    check("rst_rd_count", DATA_W'(rd_count), 0);
    check("rst_wait_low", DATA_W'(avl_waitrequest), 0);

    // Write then read on the next cycle.
    cmd(1'b0, 1'b1, 26'h00, 128'h05, '0, r);
    cmd(1'b1, 1'b0, 26'h00, '0, 128'h05, r);
    idle(1);
    drain();
    check("t1_wr_count", DATA_W'(wr_count), 1);
    check("t1_rd_count", DATA_W'(rd_count), 1);

    // Six back-to-back reads: the fifth waits one cycle for a free pending slot.
    cmd(1'b0, 1'b1, 26'h10, 128'h0A, '0, r);
    cmd(1'b0, 1'b1, 26'h00, 128'h05, '0, r);
    for (int i = 0; i < 6; i++) begin
      exp6[i] = (i % 2 == 0) ? 128'h0A : 128'h05;
      cmd(1'b1, 1'b0, (i % 2 == 0) ? 26'h10 : 26'h00, '0, exp6[i], retr[i]);
    end
    idle(1);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t2_retries%0d", i), DATA_W'(retr[i]), (i == 4) ? 1 : 0);
    end
    drain();
    check("t2_rd_count", DATA_W'(rd_count), 7);
    check("t2_wr_count", DATA_W'(wr_count), 3);

    // stall_in blocks accepts while read is held high.
    stall_in    = 1'b1;
    avl_read    = 1'b1;
    avl_address = 26'h10;
    repeat (10) @(negedge iCLK);
    #1;
    check("t3_wait_stalled", DATA_W'(avl_waitrequest), 1);
    check("t3_rd_count_stalled", DATA_W'(rd_count), 7);
    stall_in = 1'b0;
    cmd(1'b1, 1'b0, 26'h10, '0, 128'h0A, r);
    check("t3_first_cycle_accept", DATA_W'(r), 0);
    idle(1);
    drain();
    check("t3_rd_count", DATA_W'(rd_count), 8);

    // Out-of-bounds write and read.
    cmd(1'b0, 1'b1, 26'h40, 128'hDEAD, '0, r);
    idle(1);
    check("t4_err_oob", DATA_W'(err_oob), 1);
    check("t4_err_proto_clear", DATA_W'(err_proto), 0);
    cmd(1'b1, 1'b0, 26'h40, '0, 128'h0, r);
    cmd(1'b1, 1'b0, 26'h00, '0, 128'h05, r);
    idle(1);
    drain();
    check("t4_wr_count", DATA_W'(wr_count), 4);
    check("t4_rd_count", DATA_W'(rd_count), 10);

    // Simultaneous read+write: write wins, no strobe from the read.
    cmd(1'b1, 1'b1, 26'h01, 128'h77, '0, r);
    idle(1);
    check("t5_err_proto", DATA_W'(err_proto), 1);
    check("t5_wr_count", DATA_W'(wr_count), 5);
    check("t5_rd_count", DATA_W'(rd_count), 10);
    cmd(1'b1, 1'b0, 26'h01, '0, 128'h77, r);
    idle(1);
    drain();
    check("t5_err_oob_sticky", DATA_W'(err_oob), 1);

    // Reset with two reads in flight.
    cmd(1'b1, 1'b0, 26'h10, '0, 128'h0A, r);
    cmd(1'b1, 1'b0, 26'h00, '0, 128'h05, r);
    idle(1);
    iRST = 1'b1;
    sb.delete();
    @(negedge iCLK);
    iRST = 1'b0;
    check("t6_rdv_after_rst", DATA_W'(avl_readdatavalid), 0);
    check("t6_wr_count", DATA_W'(wr_count), 0);
    check("t6_rd_count", DATA_W'(rd_count), 0);
    check("t6_err_oob", DATA_W'(err_oob), 0);
    check("t6_err_proto", DATA_W'(err_proto), 0);
    idle(8);
    cmd(1'b1, 1'b0, 26'h01, '0, 128'h77, r);
    cmd(1'b1, 1'b0, 26'h10, '0, 128'h0A, r);
    idle(1);
    drain();
    check("t6_rd_count_after", DATA_W'(rd_count), 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
